// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter
//
// Merges the core's instruction-fetch bus (ireq/iresp) and data bus (dreq/dresp)
// onto a single-beat memory bus (creq/cresp). One transaction is outstanding at a
// time. The granted request is latched and held on creq until cresp_ready. The
// owner then gets a one-cycle data_ok pulse. Data has priority over fetch. A
// starvation counter forces a fetch grant after D_BURST_MAX consecutive data
// grants that were made while a fetch was waiting.
//
// Optional feature: define BUS_TIMEOUT_EN to enable a bus watchdog. A busy
// transaction that sees no cresp_ready for TIMEOUT_CYCLES cycles is completed
// with data 0, and bus_timeout pulses.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   ireq_*            fetch request in      iresp_*  addr_ok / data_ok / data out
//   dreq_*            data request in       dresp_*  addr_ok / data_ok / data out
//   creq_*            memory request out    cresp_*  ready / read data in
//   bus_timeout       watchdog pulse (always 0 without BUS_TIMEOUT_EN)

module core_bus_arbiter #(
  parameter int unsigned D_BURST_MAX    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,

  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,

  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [63:0] creq_addr,
  output logic [2:0]  creq_size,
  output logic [7:0]  creq_strobe,
  output logic [63:0] creq_data,
  input  logic        cresp_ready,
  input  logic [63:0] cresp_data,

  output logic        bus_timeout
);

  localparam int unsigned StarveW = $clog2(D_BURST_MAX + 1);

  typedef enum logic [1:0] {
    StIdle,
    StDBusy,
    StIBusy
  } state_e;

  state_e state_q, state_d;

  logic [StarveW-1:0] istarve_q, istarve_d;

  // Request register: the arbiter serves only from this copy.
  logic [63:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;

  logic        d_grant, i_grant;
  logic        busy, done, timeout;
  logic        starved;
  logic [63:0] rdata;

  assign busy    = (state_q != StIdle);
  assign starved = (istarve_q >= StarveW'(D_BURST_MAX));

  // Grants are combinational from IDLE. They are suppressed while reset is
  // asserted so no addr_ok is seen for a request that is about to be dropped.
  always_comb begin
    d_grant = 1'b0;
    i_grant = 1'b0;
    if (reset && (state_q == StIdle)) begin
      d_grant = dreq_valid && (!starved || !ireq_valid);
      i_grant = ireq_valid && !d_grant;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [15:0] tcnt_q, tcnt_d;

  // Fires while the count sits at the limit. A real ready in the same cycle
  // takes precedence and completes normally.
  assign timeout = busy && !cresp_ready && (tcnt_q == 16'(TIMEOUT_CYCLES));

  always_comb begin
    tcnt_d = tcnt_q;
    if (d_grant || i_grant) begin
      tcnt_d = '0;
    end else if (busy && !cresp_ready && !timeout) begin
      tcnt_d = tcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // A completion in the reset cycle belongs to an abandoned transaction.
  assign done = reset && busy && (cresp_ready || timeout);

  // Next-state, starvation counter and request register.
  always_comb begin
    state_d   = state_q;
    istarve_d = istarve_q;
    addr_d    = addr_q;
    size_d    = size_q;
    strobe_d  = strobe_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (d_grant) begin
          state_d  = StDBusy;
          addr_d   = dreq_addr;
          size_d   = dreq_size;
          strobe_d = dreq_strobe;
          wdata_d  = dreq_data;
        end else if (i_grant) begin
          state_d  = StIBusy;
          addr_d   = ireq_addr;
          size_d   = 3'd2;
          strobe_d = 8'h00;
          wdata_d  = 64'h0;
        end
      end
      StDBusy, StIBusy: begin
        if (done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Counts data grants made while a fetch is waiting; saturates at the limit.
    if (d_grant) begin
      if (!ireq_valid) begin
        istarve_d = '0;
      end else if (!starved) begin
        istarve_d = istarve_q + StarveW'(1);
      end
    end else if (i_grant) begin
      istarve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      istarve_q <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      strobe_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      istarve_q <= istarve_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      strobe_q  <= strobe_d;
      wdata_q   <= wdata_d;
    end
  end

  // Responses. Data is forced to 0 outside completion so that idle outputs are
  // quiet. Timeout completions always see rdata = 0.
  assign rdata = cresp_ready ? cresp_data : 64'h0;

  assign iresp_addr_ok = i_grant;
  assign dresp_addr_ok = d_grant;
  assign iresp_data_ok = done && (state_q == StIBusy);
  assign dresp_data_ok = done && (state_q == StDBusy);
  assign dresp_data    = dresp_data_ok ? rdata : 64'h0;
  assign iresp_data    = !iresp_data_ok ? 32'h0 :
                         addr_q[2]      ? rdata[63:32] : rdata[31:0];

  assign creq_valid    = busy;
  assign creq_is_write = |strobe_q;
  assign creq_addr     = addr_q;
  assign creq_size     = size_q;
  assign creq_strobe   = strobe_q;
  assign creq_data     = wdata_q;

  assign bus_timeout   = reset && timeout;

  // Only one transaction is outstanding, and its payload holds until completion.
  a_no_grant_busy : assert property (@(posedge clk) disable iff (!reset)
    busy |-> !(iresp_addr_ok || dresp_addr_ok));
  a_payload_stable : assert property (@(posedge clk) disable iff (!reset)
    (busy && !done) |=> ($stable(creq_addr) && $stable(creq_strobe) &&
                         $stable(creq_size) && $stable(creq_data)));

endmodule

// File: tb/tb_core_bus_arbiter.sv
module tb_core_bus_arbiter;

  localparam int unsigned DBurst = 4;
  localparam int unsigned Tmo    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        creq_valid, creq_is_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready;
  logic [63:0] cresp_data;
  logic        bus_timeout;

  always #5 clk = ~clk;

  core_bus_arbiter #(
    .D_BURST_MAX   (DBurst),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_addr_ok(iresp_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data),
    .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .creq_valid   (creq_valid),
    .creq_is_write(creq_is_write),
    .creq_addr    (creq_addr),
    .creq_size    (creq_size),
    .creq_strobe  (creq_strobe),
    .creq_data    (creq_data),
    .cresp_ready  (cresp_ready),
    .cresp_data   (cresp_data),
    .bus_timeout  (bus_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (0 none, 1 fetch, 2 data), how many data
  // grants a waiting fetch has sat through, busy cycles without ready, and the
  // transaction accepted at grant time.
  int          m_owner, m_starve, m_tcnt;
  logic [63:0] m_addr, m_wdata;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  bit          e_igrant, e_dgrant, e_done, e_tmo;

  function automatic void predict();
    e_igrant = 0;
    e_dgrant = 0;
    e_done   = 0;
    e_tmo    = 0;
    if (m_owner == 0) begin
      e_dgrant = dreq_valid && ((m_starve < DBurst) || !ireq_valid);
      e_igrant = ireq_valid && !e_dgrant;
    end else begin
`ifdef BUS_TIMEOUT_EN
      e_tmo = !cresp_ready && (m_tcnt == Tmo);
`endif
      e_done = cresp_ready || e_tmo;
    end
  endfunction

  task automatic model_reset();
    m_owner  = 0;
    m_starve = 0;
    m_tcnt   = 0;
    m_addr   = '0;
    m_wdata  = '0;
    m_size   = '0;
    m_strobe = '0;
  endtask

  // Compare DUT outputs against the model at the falling edge.
  task automatic sample();
    logic [63:0] rd;
    @(negedge clk);
    if (reset) begin
      predict();
      rd = e_tmo ? 64'h0 : cresp_data;
      check("iresp_addr_ok", iresp_addr_ok, e_igrant);
      check("dresp_addr_ok", dresp_addr_ok, e_dgrant);
      check("creq_valid", creq_valid, m_owner != 0);
      check("bus_timeout", bus_timeout, e_tmo);
      check("iresp_data_ok", iresp_data_ok, e_done && (m_owner == 1));
      check("dresp_data_ok", dresp_data_ok, e_done && (m_owner == 2));
      if (m_owner != 0) begin
        check("creq_addr", creq_addr, m_addr);
        check("creq_size", creq_size, m_size);
        check("creq_strobe", creq_strobe, m_strobe);
        check("creq_data", creq_data, m_wdata);
        check("creq_is_write", creq_is_write, m_strobe != 8'h00);
      end
      if (e_done && m_owner == 2) check("dresp_data", dresp_data, rd);
      if (e_done && m_owner == 1) check("iresp_data", iresp_data, m_addr[2] ? rd[63:32] : rd[31:0]);
    end
  endtask

  // Advance one clock and update the model with the inputs of that cycle.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      predict();
      if (e_dgrant) begin
        m_owner  = 2;
        m_addr   = dreq_addr;
        m_size   = dreq_size;
        m_strobe = dreq_strobe;
        m_wdata  = dreq_data;
        m_tcnt   = 0;
        m_starve = ireq_valid ? ((m_starve < DBurst) ? m_starve + 1 : m_starve) : 0;
      end else if (e_igrant) begin
        m_owner  = 1;
        m_addr   = ireq_addr;
        m_size   = 3'd2;
        m_strobe = 8'h00;
        m_wdata  = 64'h0;
        m_tcnt   = 0;
        m_starve = 0;
      end else if (m_owner != 0) begin
        if (e_done) m_owner = 0;
        else m_tcnt++;
      end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int exp_order[6] = '{2, 2, 2, 2, 1, 2};
    bit seen;

    reset       = 1'b0;
    ireq_valid  = 1'b0;
    ireq_addr   = '0;
    dreq_valid  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = '0;
    dreq_strobe = '0;
    dreq_data   = '0;
    cresp_ready = 1'b0;
    cresp_data  = '0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;

    // Quiet outputs after reset.
    sample();
    check("rst_creq_valid", creq_valid, 0);
    check("rst_creq_addr", creq_addr, 0);
    check("rst_creq_other", {creq_is_write, creq_size, creq_strobe}, 0);
    check("rst_creq_data", creq_data, 0);
    check("rst_resp", {iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok, bus_timeout}, 0);
    tick();

    // Single fetch, ready on cycle 3.
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0004;
    sample();
    check("fetch_addr_ok", iresp_addr_ok, 1);
    tick();
    sample();
    check("fetch_creq_size", creq_size, 3'd2);
    tick();
    cycle();
    cresp_ready = 1'b1;
    cresp_data  = 64'h1111_2222_3333_4444;
    sample();
    check("fetch_data_ok", iresp_data_ok, 1);
    check("fetch_data", iresp_data, 32'h1111_2222);
    tick();
    ireq_valid  = 1'b0;
    cresp_ready = 1'b0;
    cycle();

    // Store.
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8000_0010;
    dreq_size   = 3'd3;
    dreq_strobe = 8'hFF;
    dreq_data   = 64'hDEAD;
    sample();
    check("store_addr_ok", dresp_addr_ok, 1);
    tick();
    sample();
    check("store_is_write", creq_is_write, 1);
    check("store_addr", creq_addr, 64'h8000_0010);
    check("store_size", creq_size, 3'd3);
    check("store_strobe", creq_strobe, 8'hFF);
    check("store_data", creq_data, 64'hDEAD);
    tick();
    cresp_ready = 1'b1;
    sample();
    check("store_data_ok", dresp_data_ok, 1);
    tick();
    dreq_valid  = 1'b0;
    cresp_ready = 1'b0;
    cycle();

    // Priority and starvation guard with both sides held valid.
    ireq_valid  = 1'b1;
    ireq_addr   = 64'h8000_0100;
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8000_0200;
    dreq_strobe = 8'h00;
    dreq_size   = 3'd2;
    cresp_ready = 1'b1;
    for (int c = 0; c < 20 && order.size() < 6; c++) begin
      sample();
      if (dresp_addr_ok) order.push_back(2);
      else if (iresp_addr_ok) order.push_back(1);
      tick();
    end
    check("grant_count", order.size(), 6);
    for (int i = 0; i < order.size() && i < 6; i++) begin
      check($sformatf("grant_order_%0d", i), order[i], exp_order[i]);
    end
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    cycle();
    cresp_ready = 1'b0;
    cycle();

    // Reset while D_BUSY with ready present: the transaction is dropped.
    dreq_valid = 1'b1;
    dreq_addr  = 64'h8000_0300;
    cycle();
    cycle();
    reset       = 1'b0;
    cresp_ready = 1'b1;
    @(negedge clk);
    check("rstmid_no_data_ok", dresp_data_ok, 0);
    tick();
    reset       = 1'b1;
    dreq_valid  = 1'b0;
    cresp_ready = 1'b0;
    sample();
    check("rstmid_creq_valid", creq_valid, 0);
    check("rstmid_creq_addr", creq_addr, 0);
    check("rstmid_resp", {iresp_data_ok, dresp_data_ok, dresp_data}, 0);
    tick();

    // Ready in IDLE is ignored.
    cresp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("idle_ready_no_ok", {iresp_data_ok, dresp_data_ok}, 0);
      check("idle_ready_creq", creq_valid, 0);
      tick();
    end
    cresp_ready = 1'b0;

`ifdef BUS_TIMEOUT_EN
    // Fetch with no ready: watchdog completes it with data 0.
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0404;
    cycle();
    ireq_valid = 1'b0;
    seen       = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      sample();
      if (bus_timeout) begin
        seen = 1;
        check("tmo_busy_cycles", c, Tmo);
        check("tmo_data_ok", iresp_data_ok, 1);
        check("tmo_data", iresp_data, 0);
      end
      tick();
    end
    check("tmo_seen", seen, 1);
    sample();
    check("tmo_idle", creq_valid, 0);
    tick();
`else
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (bus_timeout) seen = 1;
      tick();
    end
    check("no_tmo", seen, 0);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) != 0);
      ireq_valid  = $urandom_range(0, 1) == 1;
      ireq_addr   = {$urandom(), $urandom()};
      dreq_valid  = $urandom_range(0, 1) == 1;
      dreq_addr   = {$urandom(), $urandom()};
      dreq_size   = 3'($urandom_range(0, 3));
      dreq_strobe = ($urandom_range(0, 1) == 1) ? 8'($urandom()) : 8'h00;
      dreq_data   = {$urandom(), $urandom()};
      cresp_ready = $urandom_range(0, 2) != 0;
      cresp_data  = {$urandom(), $urandom()};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
